uart_cmd_dispatcher: RTL
========================

Name: uart_cmd_dispatcher

Overview:
- Next-generation UART command front end for the sensor subsystem, generalised to NUM_CH channels.
- Receives one command byte per transaction from the UART RX path and decodes it.
- Data commands read BURST bytes from the selected channel's FIFO and send them over UART TX.
- Reset commands pulse a per-channel FSM reset and return an ACK.
- Also supports a status command, an empty-FIFO timeout and NACK on unknown commands, with a saturating error counter.

Parameters:
- DATA_DEPTH, 8: UART byte and FIFO data width.
- NUM_CH, 8: number of sensor channels. Must satisfy 1 ≤ NUM_CH ≤ DATA_DEPTH.
- CMD_DATA_BASE, 97: command for channel 0 data; channel k uses CMD_DATA_BASE+k.
- CMD_RST_BASE, 105: command for channel 0 FSM reset; channel k uses CMD_RST_BASE+k.
- CMD_STATUS, 63: status query command.
- BURST, 1: bytes sent per data command (1..16).
- RST_CYCLES, 4: width of the o_fsm_rst pulse in cycles (≥1).
- TIMEOUT, 1000: cycles to wait in FETCH for FIFO data before giving up (≥1).
- ACK_BYTE, 6: response to a reset command.
- NACK_BYTE, 21: response to an unknown command.
- EMPTY_BYTE, 255: byte sent in place of data on timeout.

Ports:
- i_clk, in, 1: clock. All logic is in this single clock domain.
- i_rst, in, 1: reset, asynchronous, active-low.
- i_uart_rx_data, in, DATA_DEPTH: received command byte.
- i_uart_rx_valid, in, 1: RX byte valid.
- o_uart_rx_ready, out, 1: dispatcher accepts a command byte.
- o_uart_tx_data, out, DATA_DEPTH: byte to send.
- o_uart_tx_valid, out, 1: TX byte valid.
- i_uart_tx_ready, in, 1: TX accepts the byte.
- i_fifo_valid, in, NUM_CH: per-channel first-word-fall-through FIFO has data.
- i_fifo_data, in, NUM_CH*DATA_DEPTH: head words; channel k occupies bits [k*DATA_DEPTH +: DATA_DEPTH].
- o_fifo_rd, out, NUM_CH: one-cycle pop strobe per channel.
- o_fsm_rst, out, NUM_CH: active-high per-channel FSM reset.
- o_busy, out, 1: high whenever state ≠ IDLE.
- o_err_cnt, out, 8: saturating count of NACKs plus timeouts.

Behaviour:
- Reset (i_rst low, asynchronous): state IDLE; all outputs 0 except o_uart_rx_ready, which is 1. Internal channel, byte and timeout counters clear; o_err_cnt clears. Reset asserted mid-transaction aborts it immediately; no partial pop or pulse completes.
- Handshakes: a transfer occurs on a cycle where valid && ready. o_uart_tx_data and o_uart_tx_valid are registered and held stable until i_uart_tx_ready.
- IDLE:
  - o_uart_rx_ready=1. On an RX handshake, latch the command and go to DECODE.
  - o_uart_rx_ready=0 in every other state, so the upstream holds further bytes.
- DECODE (1 cycle):
  - cmd in [CMD_DATA_BASE, CMD_DATA_BASE+NUM_CH-1]: ch=cmd-CMD_DATA_BASE, byte count=0, go to FETCH.
  - cmd in [CMD_RST_BASE, CMD_RST_BASE+NUM_CH-1]: ch=cmd-CMD_RST_BASE, go to RST_PULSE.
  - cmd == CMD_STATUS: tx byte = i_fifo_valid zero-extended to DATA_DEPTH (bit k = channel k), go to SEND.
  - Otherwise: tx byte = NACK_BYTE, o_err_cnt+1 (saturates at 255), go to SEND.
  - Range checks take priority in the order listed.
- FETCH:
  - If i_fifo_valid[ch]=1: o_fifo_rd[ch]=1 for exactly this cycle, tx byte = channel ch head word, timeout counter clears, go to SEND.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1: tx byte = EMPTY_BYTE, o_err_cnt+1 (saturating), go to SEND with the burst marked ended.
- SEND:
  - o_uart_tx_valid=1. On a TX handshake, o_uart_tx_valid drops the next cycle.
  - If this was a data byte and byte count < BURST-1: byte count+1, go to FETCH. Otherwise go to IDLE.
- RST_PULSE:
  - o_fsm_rst[ch]=1 for exactly RST_CYCLES consecutive cycles; no other bit is asserted.
  - Then tx byte = ACK_BYTE, go to SEND. o_fsm_rst is 0 before SEND is entered.
- Latency: RX handshake at cycle N → DECODE at N+1 → FETCH at N+2 (pop at N+2 if data is present) → o_uart_tx_valid high at N+3.
- Simultaneous events:
  - An RX byte presented in the same cycle SEND completes is not accepted until IDLE (one cycle later).
  - o_fifo_rd is never asserted for more than one channel or for more than one cycle per byte.

Test Plan:
- Reset: hold i_rst low, then release → o_uart_rx_ready=1, all other outputs 0, o_busy=0, o_err_cnt=0.
- Data read: ch2 FIFO valid with head 0x5A, send cmd 99 → o_fifo_rd=0b00000100 for 1 cycle, tx 0x5A 3 cycles after the cmd handshake; with i_uart_tx_ready stalled 5 cycles, data is held stable.
- Burst: BURST=3, ch0 FIFO head 0x11,0x22,0x33, cmd 97 → tx 0x11,0x22,0x33 and exactly 3 pops. Then ch0 empty and cmd 97 with TIMEOUT=10 → tx 0xFF after 10 FETCH cycles, o_err_cnt=1.
- FSM reset: cmd 110 → o_fsm_rst[5] high for exactly 4 cycles, then tx 0x06.
- Status/NACK: i_fifo_valid=0b10010001, cmd 63 → tx 0x91. cmd 0x7A → tx 0x15, o_err_cnt increments. 300 bad cmds → o_err_cnt=255.
- Reset mid-op: assert i_rst during the RST_PULSE and SEND states → outputs clear within the same cycle; post-reset cmd 97 works normally.

Source files
------------

// File: rtl/uart_cmd_dispatcher.sv
// uart_cmd_dispatcher
//   Command front end for the sensor subsystem. Accepts one command byte from
//   the UART RX path, decodes it and either streams BURST bytes from a
//   channel FIFO, pulses a per-channel FSM reset and ACKs, returns the FIFO
//   status vector, or NACKs. A saturating counter tracks NACKs and timeouts.
//
// Ports
//   i_clk, i_rst (async, active-low)
//   i_uart_rx_data/i_uart_rx_valid/o_uart_rx_ready : command byte in
//   o_uart_tx_data/o_uart_tx_valid/i_uart_tx_ready : response byte out
//   i_fifo_valid/i_fifo_data/o_fifo_rd             : per-channel FWFT FIFOs
//   o_fsm_rst                                      : per-channel FSM reset
//   o_busy, o_err_cnt                              : status
module uart_cmd_dispatcher #(
  parameter int DATA_DEPTH    = 8,
  parameter int NUM_CH        = 8,
  parameter int CMD_DATA_BASE = 97,
  parameter int CMD_RST_BASE  = 105,
  parameter int CMD_STATUS    = 63,
  parameter int BURST         = 1,
  parameter int RST_CYCLES    = 4,
  parameter int TIMEOUT       = 1000,
  parameter int ACK_BYTE      = 6,
  parameter int NACK_BYTE     = 21,
  parameter int EMPTY_BYTE    = 255
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [DATA_DEPTH-1:0]        i_uart_rx_data,
  input  logic                         i_uart_rx_valid,
  output logic                         o_uart_rx_ready,
  output logic [DATA_DEPTH-1:0]        o_uart_tx_data,
  output logic                         o_uart_tx_valid,
  input  logic                         i_uart_tx_ready,
  input  logic [NUM_CH-1:0]            i_fifo_valid,
  input  logic [NUM_CH*DATA_DEPTH-1:0] i_fifo_data,
  output logic [NUM_CH-1:0]            o_fifo_rd,
  output logic [NUM_CH-1:0]            o_fsm_rst,
  output logic                         o_busy,
  output logic [7:0]                   o_err_cnt
);

  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [4:0]       BURST_LAST = 5'(BURST - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_FETCH,
    S_SEND,
    S_RST
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                r_state, w_state_nxt;
  logic [DATA_DEPTH-1:0] r_cmd, w_cmd_nxt;
  logic [CH_W-1:0]       r_ch, w_ch_nxt;
  logic [4:0]            r_bcnt, w_bcnt_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_is_data, w_is_data_nxt;
  logic                  r_last, w_last_nxt;
  logic [DATA_DEPTH-1:0] r_tx_data, w_tx_nxt;
  logic                  r_tx_valid;
  logic [7:0]            r_err_cnt, w_err_nxt;

  logic [DATA_DEPTH-1:0] w_data_off, w_rst_off, w_status, w_head;
  logic                  w_is_data, w_is_rst, w_is_status, w_sel_valid;
  logic [NUM_CH-1:0]     w_ch_onehot, w_fifo_rd, w_fsm_rst;

  // Offsets wrap for commands below a base, so the >= check rejects those.
  assign w_data_off  = r_cmd - DATA_DEPTH'(CMD_DATA_BASE);
  assign w_rst_off   = r_cmd - DATA_DEPTH'(CMD_RST_BASE);
  assign w_is_data   = (r_cmd >= DATA_DEPTH'(CMD_DATA_BASE)) && (w_data_off < DATA_DEPTH'(NUM_CH));
  assign w_is_rst    = (r_cmd >= DATA_DEPTH'(CMD_RST_BASE)) && (w_rst_off < DATA_DEPTH'(NUM_CH));
  assign w_is_status = (r_cmd == DATA_DEPTH'(CMD_STATUS));
  assign w_status    = DATA_DEPTH'(i_fifo_valid);

  always_comb begin
    w_ch_onehot = '0;
    w_head      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_ch_onehot[k] = (r_ch == CH_W'(k));
      if (w_ch_onehot[k]) begin
        w_head = i_fifo_data[k*DATA_DEPTH +: DATA_DEPTH];
      end
    end
  end

  assign w_sel_valid = |(i_fifo_valid & w_ch_onehot);

  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_nxt     = r_cmd;
    w_ch_nxt      = r_ch;
    w_bcnt_nxt    = r_bcnt;
    w_cnt_nxt     = r_cnt;
    w_is_data_nxt = r_is_data;
    w_last_nxt    = r_last;
    w_tx_nxt      = r_tx_data;
    w_err_nxt     = r_err_cnt;
    w_fifo_rd     = '0;
    w_fsm_rst     = '0;
    unique case (r_state)
      S_IDLE: begin
        if (i_uart_rx_valid) begin
          w_cmd_nxt   = i_uart_rx_data;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        w_cnt_nxt = '0;
        if (w_is_data) begin
          w_ch_nxt      = w_data_off[CH_W-1:0];
          w_bcnt_nxt    = '0;
          w_is_data_nxt = 1'b1;
          w_last_nxt    = 1'b0;
          w_state_nxt   = S_FETCH;
        end else if (w_is_rst) begin
          w_ch_nxt      = w_rst_off[CH_W-1:0];
          w_is_data_nxt = 1'b0;
          w_state_nxt   = S_RST;
        end else if (w_is_status) begin
          w_tx_nxt      = w_status;
          w_is_data_nxt = 1'b0;
          w_state_nxt   = S_SEND;
        end else begin
          w_tx_nxt      = DATA_DEPTH'(NACK_BYTE);
          w_err_nxt     = sat_inc(r_err_cnt);
          w_is_data_nxt = 1'b0;
          w_state_nxt   = S_SEND;
        end
      end
      S_FETCH: begin
        if (w_sel_valid) begin
          // FWFT: the head word is consumed in the same cycle it is captured.
          w_fifo_rd   = w_ch_onehot;
          w_tx_nxt    = w_head;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SEND;
        end else if (r_cnt == TMO_LAST) begin
          w_tx_nxt    = DATA_DEPTH'(EMPTY_BYTE);
          w_err_nxt   = sat_inc(r_err_cnt);
          w_last_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SEND;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_SEND: begin
        if (i_uart_tx_ready) begin
          if (r_is_data && !r_last && (r_bcnt < BURST_LAST)) begin
            w_bcnt_nxt  = r_bcnt + 5'd1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RST: begin
        w_fsm_rst = w_ch_onehot;
        if (r_cnt == RST_LAST) begin
          w_tx_nxt    = DATA_DEPTH'(ACK_BYTE);
          w_cnt_nxt   = '0;
          w_state_nxt = S_SEND;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_cmd      <= '0;
      r_ch       <= '0;
      r_bcnt     <= '0;
      r_cnt      <= '0;
      r_is_data  <= 1'b0;
      r_last     <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmd      <= w_cmd_nxt;
      r_ch       <= w_ch_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_cnt      <= w_cnt_nxt;
      r_is_data  <= w_is_data_nxt;
      r_last     <= w_last_nxt;
      r_tx_data  <= w_tx_nxt;
      r_tx_valid <= (w_state_nxt == S_SEND);
      r_err_cnt  <= w_err_nxt;
    end
  end

  assign o_uart_rx_ready = (r_state == S_IDLE);
  assign o_busy          = (r_state != S_IDLE);
  assign o_uart_tx_data  = r_tx_data;
  assign o_uart_tx_valid = r_tx_valid;
  assign o_fifo_rd       = w_fifo_rd;
  assign o_fsm_rst       = w_fsm_rst;
  assign o_err_cnt       = r_err_cnt;

endmodule
